// File: rtl/servo_pulse_decoder.sv
// -----------------------------------------------------------------------------
// servo_pulse_decoder
//
// Measures the high time of an incoming hobby-servo / RC-receiver pulse train
// and reports it in whole microseconds (1500 = centre), in the same units a
// servo PWM generator takes on its pulse-length input. Out-of-range pulses and
// loss of signal are flagged.
//
// Ports:
//   CLK        in   1   system clock
//   rst        in   1   synchronous active-high reset
//   PWM_IN     in   1   asynchronous servo pulse input
//   pul_len    out  16  last accepted pulse width in us (1500 after reset)
//   pul_valid  out  1   one-cycle strobe when pul_len is updated
//   err_range  out  1   one-cycle strobe when a completed pulse is rejected,
//                       or when the pin is stuck high past the timeout
//   signal_ok  out  1   high while valid pulses keep arriving
//
// Output protocol: pul_valid and err_range are single-cycle strobes with no
// back-pressure; the consumer must sample them in the cycle they are high.
// They are mutually exclusive and never high in two consecutive cycles. The
// strobe for a pulse appears in the cycle after the third CLK edge following
// the PWM_IN falling edge (two synchronizer edges plus one register edge).
//
// TIMEOUT_US, MAX_US and MIN_US must fit in 16 bits.
// -----------------------------------------------------------------------------
module servo_pulse_decoder #(
  parameter int CLK_PER_US = 50,
  parameter int MIN_US     = 500,
  parameter int MAX_US     = 2500,
  parameter int TIMEOUT_US = 25000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        PWM_IN,
  output logic [15:0] pul_len,
  output logic        pul_valid,
  output logic        err_range,
  output logic        signal_ok
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int SUB_W = $clog2(CLK_PER_US + 1);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLK_PER_US - 1);

  // Counter values after exactly one counted cycle. The rise cycle itself has
  // s2=1, so it is counted: the counters restart at "one cycle elapsed"
  // rather than zero.
  localparam logic [SUB_W-1:0] SUB_FIRST = (CLK_PER_US == 1) ? SUB_W'(0) : SUB_W'(1);
  localparam logic [15:0]      US_FIRST  = (CLK_PER_US == 1) ? 16'd1 : 16'd0;

  localparam logic [15:0] MIN_W     = 16'(MIN_US);
  localparam logic [15:0] MAX_W     = 16'(MAX_US);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_US);
  localparam logic [15:0] RESET_LEN = 16'd1500;
  localparam logic [15:0] US_SAT    = 16'hFFFF;

  localparam logic [1:0] ST_WAIT_LOW = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_HIGH     = 2'd2;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic       s1_q;
  logic       s2_q;
  logic       s3_q;
  // Marks that s2 holds a real sample of the pin. Without it the cleared
  // synchronizer would look like a low pin right after reset, and a pin that
  // is still high at reset release would be measured as a fresh pulse.
  logic [1:0] primed_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      primed_q <= 2'b00;
    end else begin
      s1_q     <= PWM_IN;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      primed_q <= {primed_q[0], 1'b1};
    end
  end

  logic rise;
  logic fall;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [SUB_W-1:0] sub_q, sub_d;     // sub-us cycle count of the high time
  logic [15:0]      us_q, us_d;       // whole us of the high time
  logic [SUB_W-1:0] fsub_q, fsub_d;   // sub-us cycle count since the last rise
  logic [15:0]      fus_q, fus_d;     // whole us since the last rise
  logic [15:0]      pul_len_q, pul_len_d;
  logic             pul_valid_q, pul_valid_d;
  logic             err_range_q, err_range_d;
  logic             signal_ok_q, signal_ok_d;

  // One-cycle advance of the width counter pair. The us part saturates; the
  // sub-us part keeps wrapping, which is harmless once us is pinned.
  logic [SUB_W-1:0] sub_tick;
  logic [15:0]      us_tick;
  logic [SUB_W-1:0] fsub_tick;
  logic [15:0]      fus_tick;

  always_comb begin
    sub_tick = sub_q;
    us_tick  = us_q;
    if (sub_q == SUB_LAST) begin
      sub_tick = '0;
      if (us_q != US_SAT) begin
        us_tick = us_q + 16'd1;
      end
    end else begin
      sub_tick = sub_q + SUB_W'(1);
    end
  end

  always_comb begin
    fsub_tick = fsub_q;
    fus_tick  = fus_q;
    if (fsub_q == SUB_LAST) begin
      fsub_tick = '0;
      if (fus_q != US_SAT) begin
        fus_tick = fus_q + 16'd1;
      end
    end else begin
      fsub_tick = fsub_q + SUB_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    us_d        = us_q;
    fsub_d      = fsub_tick;
    fus_d       = fus_tick;
    pul_len_d   = pul_len_q;
    pul_valid_d = 1'b0;
    err_range_d = 1'b0;
    signal_ok_d = signal_ok_q;

    case (state_q)
      // Discard whatever the pin is doing until it is seen low, so a partial
      // pulse is never measured.
      ST_WAIT_LOW: begin
        if (primed_q[1] && !s2_q) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (rise) begin
          sub_d   = SUB_FIRST;
          us_d    = US_FIRST;
          fsub_d  = SUB_FIRST;
          fus_d   = US_FIRST;
          state_d = ST_HIGH;
        end else if (fus_q > TIMEOUT_W) begin
          signal_ok_d = 1'b0;
        end
      end

      // In this state s2=0 only ever appears as a fall, since s3 was high.
      ST_HIGH: begin
        if (fall) begin
          state_d = ST_ARMED;
          if ((us_q >= MIN_W) && (us_q <= MAX_W)) begin
            pul_len_d   = us_q;
            pul_valid_d = 1'b1;
            signal_ok_d = 1'b1;
          end else begin
            err_range_d = 1'b1;
          end
        end else if (us_q > TIMEOUT_W) begin
          // Stuck high: report once, then ignore the eventual falling edge.
          signal_ok_d = 1'b0;
          err_range_d = 1'b1;
          state_d     = ST_WAIT_LOW;
        end else begin
          sub_d = sub_tick;
          us_d  = us_tick;
        end
      end

      default: begin
        state_d = ST_WAIT_LOW;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= ST_WAIT_LOW;
      sub_q       <= '0;
      us_q        <= '0;
      fsub_q      <= '0;
      fus_q       <= '0;
      pul_len_q   <= RESET_LEN;
      pul_valid_q <= 1'b0;
      err_range_q <= 1'b0;
      signal_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      us_q        <= us_d;
      fsub_q      <= fsub_d;
      fus_q       <= fus_d;
      pul_len_q   <= pul_len_d;
      pul_valid_q <= pul_valid_d;
      err_range_q <= err_range_d;
      signal_ok_q <= signal_ok_d;
    end
  end

  assign pul_len   = pul_len_q;
  assign pul_valid = pul_valid_q;
  assign err_range = err_range_q;
  assign signal_ok = signal_ok_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// -----------------------------------------------------------------------------
// tb_servo_pulse_decoder
//
// Drives pulse trains into servo_pulse_decoder with scaled-down timing
// parameters so loss-of-signal and stuck-high cases fit in a short run.
// Each pulse's expected outcome (kind, width, signal_ok, strobe cycle) is
// derived from the pulse length with plain integer arithmetic and queued;
// a monitor pops and compares whenever the DUT strobes.
// -----------------------------------------------------------------------------
module tb_servo_pulse_decoder;

  localparam int C   = 3;     // clock cycles per us
  localparam int MIN = 50;
  localparam int MAX = 250;
  localparam int TO  = 1000;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        pwm;
  logic [15:0] pul_len;
  logic        pul_valid;
  logic        err_range;
  logic        signal_ok;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  servo_pulse_decoder #(
    .CLK_PER_US (C),
    .MIN_US     (MIN),
    .MAX_US     (MAX),
    .TIMEOUT_US (TO)
  ) dut (
    .CLK       (clk),
    .rst       (rst),
    .PWM_IN    (pwm),
    .pul_len   (pul_len),
    .pul_valid (pul_valid),
    .err_range (err_range),
    .signal_ok (signal_ok)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  // exp_q item: [17] signal_ok after the event, [16] 1=accepted 0=rejected,
  // [15:0] pul_len expected in the strobe cycle.
  logic [17:0] exp_q[$];
  int          exp_cyc_q[$];   // cycle of the strobe, -1 when not pinned

  int          n_vec  = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [15:0] mon_len = 16'd1500;

  // Reference model state
  logic [15:0] model_len = 16'd1500;
  logic        model_sok = 1'b0;
  int          prev_rise = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [17:0] item;
    int          ecyc;
    if (mon_en) begin
      if (rst) begin
        mon_len = 16'd1500;
      end else if (pul_valid || err_range) begin
        check("strobe_overlap", {31'd0, pul_valid & err_range}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {30'd0, pul_valid, err_range}, 32'd0);
        end else begin
          item = exp_q.pop_front();
          ecyc = exp_cyc_q.pop_front();
          check("pul_valid", {31'd0, pul_valid}, {31'd0, item[16]});
          check("err_range", {31'd0, err_range}, {31'd0, ~item[16]});
          check("pul_len", {16'd0, pul_len}, {16'd0, item[15:0]});
          check("signal_ok", {31'd0, signal_ok}, {31'd0, item[17]});
          if (ecyc >= 0) check("strobe_cycle", cyc, ecyc);
          if (item[16]) mon_len = item[15:0];
        end
      end else begin
        check("pul_len_hold", {16'd0, pul_len}, {16'd0, mon_len});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic push_exp(input logic sok, input logic ok, input logic [15:0] len, input int ecyc);
    exp_q.push_back({sok, ok, len});
    exp_cyc_q.push_back(ecyc);
  endtask

  // One pulse: high for hi cycles, then low for lo cycles.
  task automatic pulse(input int hi, input int lo);
    int w;
    int rise_c;
    @(posedge clk);
    #1 pwm = 1'b1;
    rise_c = cyc;
    // Gap since the previous rise longer than the timeout drops signal_ok.
    if (prev_rise >= 0 && ((rise_c - prev_rise) / C) > TO) model_sok = 1'b0;
    prev_rise = rise_c;
    w = hi / C;
    if (w > TO) begin
      model_sok = 1'b0;
      push_exp(1'b0, 1'b0, model_len, -1);
    end else if (w >= MIN && w <= MAX) begin
      model_len = 16'(w);
      model_sok = 1'b1;
      push_exp(1'b1, 1'b1, model_len, rise_c + hi + 3);
    end else begin
      push_exp(model_sok, 1'b0, model_len, rise_c + hi + 3);
    end
    repeat (hi) @(posedge clk);
    #1 pwm = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  // A pulse with a one-cycle reset in the middle of its high time.
  task automatic pulse_with_reset(input int hi, input int lo);
    @(posedge clk);
    #1 pwm = 1'b1;
    repeat (hi / 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_len = 16'd1500;
    model_sok = 1'b0;
    prev_rise = -1;
    @(negedge clk);
    check("rst_mid_pul_len", {16'd0, pul_len}, 32'd1500);
    check("rst_mid_signal_ok", {31'd0, signal_ok}, 32'd0);
    check("rst_mid_strobes", {30'd0, pul_valid, err_range}, 32'd0);
    repeat (hi - hi / 2) @(posedge clk);
    #1 pwm = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic check_sok();
    @(negedge clk);
    if (prev_rise >= 0 && ((cyc - prev_rise) / C) > TO + 5) model_sok = 1'b0;
    check("signal_ok_level", {31'd0, signal_ok}, {31'd0, model_sok});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int hi;
    int cat;

    rst = 1'b1;
    pwm = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pul_len", {16'd0, pul_len}, 32'd1500);
    check("reset_pul_valid", {31'd0, pul_valid}, 32'd0);
    check("reset_err_range", {31'd0, err_range}, 32'd0);
    check("reset_signal_ok", {31'd0, signal_ok}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(posedge clk);

    // Centre pulse, then width boundaries.
    pulse(150 * C, 200);
    check_sok();
    pulse(100 * C + C - 1, 100);     // 100
    pulse(250 * C - 1, 100);         // 249
    pulse(MIN * C, 100);             // exactly MIN
    pulse(MAX * C, 100);             // exactly MAX
    pulse((MAX + 1) * C - 1, 100);   // still MAX
    pulse((MAX + 1) * C, 100);       // MAX+1, rejected
    pulse(MIN * C - 1, 100);         // MIN-1, rejected
    pulse(1, 100);                   // W=0, rejected

    // Range errors after a good pulse keep pul_len and signal_ok.
    pulse(150 * C, 100);
    pulse(40 * C, 100);
    pulse(260 * C, 100);
    check_sok();

    // Randomized mix of accepted and rejected widths.
    for (int i = 0; i < 40; i++) begin
      cat = int'($urandom_range(0, 3));
      if (cat <= 1)      hi = int'($urandom_range(MIN * C, (MAX + 1) * C - 1));
      else if (cat == 2) hi = int'($urandom_range(1, MIN * C - 1));
      else               hi = int'($urandom_range((MAX + 1) * C, 600 * C));
      pulse(hi, int'($urandom_range(20, 300)));
    end

    // Loss of signal while low, then recovery.
    pulse(150 * C, 3600);
    check_sok();
    pulse(120 * C, 100);
    check_sok();

    // Stuck high: one err_range, the late fall is ignored, then recovery.
    pulse(3500, 100);
    check_sok();
    pulse(180 * C, 100);

    // Reset in the middle of a pulse; the pulse is not reported.
    pulse_with_reset(150 * C, 200);
    pulse(170 * C, 100);
    check_sok();

    repeat (20) @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
